// File: rtl/rand_pool.sv
// Entropy harvester: synchronises a noisy bit, optionally debiases (von Neumann)
// and whitens it (16-bit LFSR), packs LSB-first words into a small FWFT FIFO.
module rand_pool #(
  parameter int WS    = 16,
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic                     iCLK,
  input  logic                     iRST,
  input  logic                     iIn,
  input  logic                     iSample,
  input  logic [1:0]               iMode,
  output logic [WS-1:0]            oData,
  output logic                     oValid,
  input  logic                     iReady,
  output logic [$clog2(DEPTH):0]   oCount,
  output logic [CNT_W-1:0]         oDrop
);

  localparam int IW = (WS > 2) ? $clog2(WS) : 1;
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(WS - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic              sync1_q, sync2_q;
  logic [1:0]        mode_q;
  logic              pend_q, pend_d;
  logic              first_q, first_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [WS-2:0]     buf_q, buf_d;
  logic [15:0]       lfsr_q, lfsr_d;
  logic [WS-1:0]     mem_q [DEPTH];
  logic [PW-1:0]     wptr_q, wptr_d;
  logic [PW-1:0]     rptr_q, rptr_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [CNT_W-1:0]  drop_q, drop_d;

  logic              mode_chg;
  logic              pend_eff;
  logic [IW-1:0]     idx_eff;
  logic              emit;
  logic              raw_bit;
  logic              out_bit;
  logic              push;
  logic [WS-1:0]     push_word;
  logic              empty, full, pop, wr, drop_inc;

  // A mode change restarts bit collection; the sample of that cycle is the new first bit.
  always_comb begin
    mode_chg = (iMode != mode_q);
    pend_eff = pend_q & ~mode_chg;
    idx_eff  = mode_chg ? '0 : idx_q;
    emit     = 1'b0;
    raw_bit  = sync2_q;
    pend_d   = pend_eff;
    first_d  = first_q;
    if (iSample) begin
      if (iMode[0]) begin
        if (pend_eff) begin
          pend_d  = 1'b0;
          emit    = (first_q != sync2_q);
          raw_bit = first_q;
        end else begin
          pend_d  = 1'b1;
          first_d = sync2_q;
        end
      end else begin
        emit = 1'b1;
      end
    end
  end

  always_comb begin
    out_bit = raw_bit ^ (iMode[1] & lfsr_q[0]);
    lfsr_d  = lfsr_q;
    if (emit && iMode[1]) begin
      lfsr_d = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
    end
  end

  always_comb begin
    buf_d     = buf_q;
    idx_d     = idx_eff;
    push      = 1'b0;
    push_word = {out_bit, buf_q};
    if (emit) begin
      if (idx_eff == LAST_IDX) begin
        push  = 1'b1;
        idx_d = '0;
      end else begin
        buf_d[idx_eff] = out_bit;
        idx_d          = idx_eff + 1'b1;
      end
    end
  end

  // No fall-through bypass: an empty FIFO cannot pop, so a push into it is push-only.
  always_comb begin
    empty    = (cnt_q == '0);
    full     = (cnt_q == FULL_CNT);
    pop      = ~empty & iReady;
    wr       = push & (~full | pop);
    drop_inc = push & full & ~pop;
    wptr_d   = wr  ? wptr_q + 1'b1 : wptr_q;
    rptr_d   = pop ? rptr_q + 1'b1 : rptr_q;
    cnt_d    = cnt_q;
    if (wr && !pop) begin
      cnt_d = cnt_q + 1'b1;
    end else if (pop && !wr) begin
      cnt_d = cnt_q - 1'b1;
    end
    drop_d = drop_q;
    if (drop_inc && (drop_q != '1)) begin
      drop_d = drop_q + 1'b1;
    end
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      mode_q  <= 2'b00;
      pend_q  <= 1'b0;
      first_q <= 1'b0;
      idx_q   <= '0;
      buf_q   <= '0;
      lfsr_q  <= 16'hACE1;
      wptr_q  <= '0;
      rptr_q  <= '0;
      cnt_q   <= '0;
      drop_q  <= '0;
    end else begin
      sync1_q <= iIn;
      sync2_q <= sync1_q;
      mode_q  <= iMode;
      pend_q  <= pend_d;
      first_q <= first_d;
      idx_q   <= idx_d;
      buf_q   <= buf_d;
      lfsr_q  <= lfsr_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      cnt_q   <= cnt_d;
      drop_q  <= drop_d;
    end
  end

  // Storage needs no reset: oData is forced to 0 whenever the FIFO is empty.
  always_ff @(posedge iCLK) begin
    if (!iRST && wr) begin
      mem_q[wptr_q] <= push_word;
    end
  end

  assign oData  = empty ? '0 : mem_q[rptr_q];
  assign oValid = ~empty;
  assign oCount = cnt_q;
  assign oDrop  = drop_q;

endmodule

// File: tb/tb_rand_pool.sv
// Bench for rand_pool: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then a randomized phase.
module tb_rand_pool;
  localparam int WS = 16;
  localparam int DEPTH = 4;
  localparam int CNT_W = 8;

  logic              clk = 1'b0;
  logic              iRST = 1'b1, iIn = 1'b0, iSample = 1'b0, iReady = 1'b0;
  logic [1:0]        iMode = 2'b00;
  logic [WS-1:0]     oData;
  logic              oValid;
  logic [$clog2(DEPTH):0] oCount;
  logic [CNT_W-1:0]  oDrop;

  int n_cmp = 0;
  int n_err = 0;

  rand_pool #(.WS(WS), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .iCLK(clk), .iRST(iRST), .iIn(iIn), .iSample(iSample), .iMode(iMode),
    .oData(oData), .oValid(oValid), .iReady(iReady), .oCount(oCount), .oDrop(oDrop));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: history queue, bit queue for the partial word, word queue for the FIFO.
  bit        started = 0;
  bit        hist[$];
  bit        part[$];
  logic [WS-1:0] fifo[$];
  bit        m_pend, m_a;
  logic [15:0] m_lfsr;
  int        m_drop;
  logic [1:0] m_prev;

  function automatic logic [15:0] lfsr_next(input logic [15:0] l);
    return {l[0] ^ l[2] ^ l[3] ^ l[5], l[15:1]};
  endfunction

  always @(posedge clk) begin
    bit s, e, emit, popm, was_full;
    logic [WS-1:0] w;
    if (iRST) begin
      hist = '{0, 0};
      part.delete();
      fifo.delete();
      m_pend = 0; m_a = 0;
      m_lfsr = 16'hACE1;
      m_drop = 0;
      m_prev = 2'b00;
      started = 1;
    end else if (started) begin
      s = hist[0];
      void'(hist.pop_front());
      hist.push_back(iIn);
      if (iMode != m_prev) begin
        part.delete();
        m_pend = 0;
      end
      emit = 0; e = 0;
      if (iSample) begin
        if (iMode[0]) begin
          if (!m_pend) begin
            m_a = s; m_pend = 1;
          end else begin
            m_pend = 0;
            if (m_a != s) begin emit = 1; e = m_a; end
          end
        end else begin
          emit = 1; e = s;
        end
      end
      popm = (fifo.size() > 0) && iReady;
      was_full = (fifo.size() == DEPTH);
      if (popm) void'(fifo.pop_front());
      if (emit) begin
        if (iMode[1]) begin
          e = e ^ m_lfsr[0];
          m_lfsr = lfsr_next(m_lfsr);
        end
        part.push_back(e);
        if (part.size() == WS) begin
          w = '0;
          for (int i = 0; i < WS; i++) w[i] = part[i];
          part.delete();
          if (was_full && !popm) begin
            if (m_drop < (1 << CNT_W) - 1) m_drop++;
          end else begin
            fifo.push_back(w);
          end
        end
      end
      m_prev = iMode;
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("valid", 32'(oValid), 32'(fifo.size() > 0));
      chk("data", 32'(oData), (fifo.size() > 0) ? 32'(fifo[0]) : 32'h0);
      chk("count", 32'(oCount), 32'(fifo.size()));
      chk("drop", 32'(oDrop), 32'(m_drop));
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic send_bit(input bit b, input bit rdy);
    iIn = b; iSample = 1'b0;
    repeat (3) step();
    iSample = 1'b1; iReady = rdy;
    step();
    iSample = 1'b0; iReady = 1'b0;
  endtask

  task automatic send_word(input logic [WS-1:0] w, input bit rdy_last);
    for (int i = 0; i < WS; i++) send_bit(w[i], (i == WS - 1) && rdy_last);
  endtask

  task automatic send_vn_word(input logic [WS-1:0] w);
    for (int i = 0; i < WS; i++) begin
      send_bit(i[0], 0); send_bit(i[0], 0);
      send_bit(w[i], 0); send_bit(!w[i], 0);
    end
  endtask

  task automatic pop_chk(input string name, input logic [WS-1:0] exp);
    chk(name, 32'(oData), 32'(exp));
    iReady = 1'b1; step(); iReady = 1'b0;
  endtask

  task automatic do_reset();
    iRST = 1'b1; step(); step(); iRST = 1'b0;
  endtask

  logic [WS-1:0] words[6];
  logic [WS-1:0] tmp;

  initial begin
    step(); step();
    iRST = 1'b0;
    chk("reset_valid", 32'(oValid), 32'h0);
    chk("reset_count", 32'(oCount), 32'h0);

    // 1: raw word
    send_word(16'hA5C3, 0);
    chk("t1_valid", 32'(oValid), 32'h1);
    chk("t1_count", 32'(oCount), 32'h1);
    pop_chk("t1_data", 16'hA5C3);

    // 2: von Neumann, equal pairs interleaved
    iMode = 2'b01; step();
    send_vn_word(16'hAAAA);
    pop_chk("t2_data", 16'hAAAA);

    // 3: whitened raw, zero input exposes the LFSR sequence
    iMode = 2'b10; step();
    send_word(16'h0000, 0);
    chk("t3_data", 32'(oData), 32'hACE1);
    send_word(16'h0000, 0);
    chk("t3_count", 32'(oCount), 32'h2);

    // 4: overflow with consumer stalled
    iMode = 2'b00;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      words[i] = WS'($urandom);
      send_word(words[i], 0);
    end
    chk("t4_count", 32'(oCount), 32'h4);
    chk("t4_drop", 32'(oDrop), 32'h2);
    for (int i = 0; i < 4; i++) pop_chk("t4_pop", words[i]);
    chk("t4_empty_valid", 32'(oValid), 32'h0);
    chk("t4_empty_data", 32'(oData), 32'h0);

    // 5: push and pop together while full
    for (int i = 0; i < 4; i++) begin
      words[i] = WS'($urandom);
      send_word(words[i], 0);
    end
    words[4] = WS'($urandom);
    send_word(words[4], 1);
    chk("t5_drop", 32'(oDrop), 32'h2);
    chk("t5_count", 32'(oCount), 32'h4);
    for (int i = 1; i < 5; i++) pop_chk("t5_pop", words[i]);

    // 6: reset and mode change discard partial words
    for (int i = 0; i < 8; i++) send_bit(1'($urandom), 0);
    do_reset();
    chk("t6_valid", 32'(oValid), 32'h0);
    chk("t6_data", 32'(oData), 32'h0);
    chk("t6_count", 32'(oCount), 32'h0);
    chk("t6_drop", 32'(oDrop), 32'h0);
    tmp = WS'($urandom);
    send_word(tmp, 0);
    pop_chk("t6_fresh", tmp);
    for (int i = 0; i < 8; i++) send_bit(1'($urandom), 0);
    iMode = 2'b01; step();
    tmp = 16'h3C96;
    send_vn_word(tmp);
    chk("t6_mode_count", 32'(oCount), 32'h1);
    pop_chk("t6_mode_data", tmp);

    // randomized phase against the model
    for (int c = 0; c < 6000; c++) begin
      iIn     = 1'($urandom);
      iSample = ($urandom_range(0, 2) == 0);
      iReady  = ($urandom_range(0, 5) == 0);
      iRST    = ($urandom_range(0, 999) == 0);
      if ($urandom_range(0, 199) == 0) iMode = 2'($urandom);
      step();
    end
    iRST = 1'b0; iSample = 1'b0; iReady = 1'b0;
    step(); step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
